// File: rtl/elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module : elevator_ctrl_n
// Brief  : N-floor SCAN elevator controller with latched hall/car calls and
//          timed travel/door-dwell. Optional ELEVATOR_FIRE_RECALL_EN adds
//          the fire recall input.
// Rev    : 1.0
// ============================================================================
module elevator_ctrl_n #(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6,
  parameter int HOME_FLOOR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
`ifdef ELEVATOR_FIRE_RECALL_EN
  input  logic              fire,
`endif
  input  logic [FLOORS-1:0] in_eb,
  input  logic [FLOORS-1:0] in_up,
  input  logic [FLOORS-1:0] in_down,
  output logic [FLOORS-1:0] q,
  output logic [FLOORS-1:0] q_eb,
  output logic [FLOORS-1:0] q_up,
  output logic [FLOORS-1:0] q_down,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open
);

  localparam int FW   = $clog2(FLOORS);
  localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [FW-1:0]     TOP_FLOOR   = FW'(FLOORS - 1);
  localparam logic [FW-1:0]     HOME        = FW'(HOME_FLOOR);
  localparam logic [CW-1:0]     TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0]     DOOR_LAST   = CW'(DOOR_CYCLES - 1);
  localparam logic [FLOORS-1:0] ONE         = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FLOORS-1:0] UP_VALID    = ~(ONE << (FLOORS - 1));
  localparam logic [FLOORS-1:0] DN_VALID    = ~ONE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_up_q, dir_up_d;
  logic [FLOORS-1:0] eb_q, eb_d, up_q, up_d, dn_q, dn_d;

  logic [FLOORS-1:0] all_q, floor_mask, entry_mask;
  logic [FLOORS-1:0] set_eb, set_up, set_dn, clr_eb, clr_up, clr_dn;
  logic [FW-1:0]     next_floor, entry_floor;
  logic              here, above, below, beyond_next, stop_next, press_here;
  logic              entry, fire_act;

`ifdef ELEVATOR_FIRE_RECALL_EN
  assign fire_act = fire;
`else
  assign fire_act = 1'b0;
`endif

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i < int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  assign all_q      = eb_q | up_q | dn_q;
  assign floor_mask = ONE << floor_q;
  assign here       = all_q[floor_q];
  assign above      = any_above(all_q, floor_q);
  assign below      = any_below(all_q, floor_q);
  assign press_here = |((in_eb | (in_up & UP_VALID) | (in_down & DN_VALID)) & floor_mask);

  // Clamped one-step neighbour in the travel direction; never leaves the shaft.
  always_comb begin
    next_floor = floor_q;
    if (dir_up_q) begin
      if (floor_q != TOP_FLOOR) next_floor = floor_q + 1'b1;
    end else begin
      if (floor_q != '0) next_floor = floor_q - 1'b1;
    end
  end

  assign beyond_next = dir_up_q ? any_above(all_q, next_floor) : any_below(all_q, next_floor);
  assign stop_next   = eb_q[next_floor]
                     | (dir_up_q ? up_q[next_floor] : dn_q[next_floor])
                     | (all_q[next_floor] & ~beyond_next);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    floor_d     = floor_q;
    dir_up_d    = dir_up_q;
    set_eb      = in_eb;
    set_up      = in_up & UP_VALID;
    set_dn      = in_down & DN_VALID;
    clr_eb      = '0;
    clr_up      = '0;
    clr_dn      = '0;
    entry       = 1'b0;
    entry_floor = floor_q;
    entry_mask  = '0;

    case (state_q)
      S_IDLE: begin
        if (fire_act) begin
          cnt_d = '0;
          if (floor_q == HOME) begin
            state_d = S_DOOR;
          end else begin
            state_d  = S_MOVE;
            dir_up_d = (HOME > floor_q);
          end
        end else if (here) begin
          state_d = S_DOOR;
          cnt_d   = '0;
          entry   = 1'b1;
        end else if (dir_up_q ? above : below) begin
          state_d = S_MOVE;
          cnt_d   = '0;
        end else if (dir_up_q ? below : above) begin
          state_d  = S_MOVE;
          cnt_d    = '0;
          dir_up_d = ~dir_up_q;
        end
      end

      S_MOVE: begin
        if (cnt_q != TRAVEL_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          floor_d = next_floor;
          if (fire_act) begin
            // Recall: finish this floor, then head for home without stopping.
            if (next_floor == HOME) state_d = S_DOOR;
            else                    dir_up_d = (HOME > next_floor);
          end else if (stop_next) begin
            state_d     = S_DOOR;
            entry       = 1'b1;
            entry_floor = next_floor;
          end else if (!beyond_next) begin
            state_d = S_IDLE;
          end
        end
      end

      S_DOOR: begin
        set_eb = set_eb & ~floor_mask;
        set_up = set_up & ~floor_mask;
        set_dn = set_dn & ~floor_mask;
        if (fire_act && (floor_q == HOME)) begin
          cnt_d = '0;
        end else if (press_here && !fire_act) begin
          cnt_d = '0;
        end else if (cnt_q == DOOR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Calls answered by this stop; the opposite hall call is served too
    // when nothing remains ahead in the travel direction.
    if (entry) begin
      entry_mask = ONE << entry_floor;
      clr_eb     = entry_mask;
      if (dir_up_q) begin
        clr_up = entry_mask;
        if (!any_above(all_q, entry_floor)) clr_dn = entry_mask;
      end else begin
        clr_dn = entry_mask;
        if (!any_below(all_q, entry_floor)) clr_up = entry_mask;
      end
    end

    eb_d = (eb_q & ~clr_eb) | set_eb;
    up_d = (up_q & ~clr_up) | set_up;
    dn_d = (dn_q & ~clr_dn) | set_dn;
    if (fire_act) begin
      eb_d = '0;
      up_d = '0;
      dn_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      floor_q  <= HOME;
      dir_up_q <= 1'b1;
      eb_q     <= '0;
      up_q     <= '0;
      dn_q     <= '0;
    end else if (init) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      floor_q  <= HOME;
      dir_up_q <= 1'b1;
      eb_q     <= '0;
      up_q     <= '0;
      dn_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      floor_q  <= floor_d;
      dir_up_q <= dir_up_d;
      eb_q     <= eb_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
    end
  end

  assign q         = ONE << floor_q;
  assign q_eb      = eb_q;
  assign q_up      = up_q;
  assign q_down    = dn_q;
  assign dir_up    = dir_up_q;
  assign moving    = (state_q == S_MOVE);
  assign door_open = (state_q == S_DOOR);

endmodule
`default_nettype wire
